// File: rtl/cc_param.sv
`default_nettype none
// ============================================================================
// Module      : cc_param
// Description : Parametrised signed cross-correlator. Captures an N-sample
//               window of two streams (a, b) and then evaluates
//                 corr[lag] = sum_{n=0..N-1} a[n]*b[n+lag],  lag = -LMAX..+LMAX
//               with b outside 0..N-1 reading as zero. One MAC per cycle.
//               Reports the lag with the largest correlation and its sum.
//               Ties keep the most negative lag.
//
// Parameters  : W    sample width (signed)
//               N    window length (power of 2, >= 4)
//               LMAX max |lag| (1..N-1)
//               ACCW derived accumulator width = 2*W + log2(N)
//               LAGW derived signed lag width  = clog2(LMAX+1) + 1
//
// Ports       : clk, rst          clock / synchronous active-high reset
//               start             begin capture (honoured in IDLE or DONE)
//               in_valid/in_ready sample-pair handshake (ready only in LOAD)
//               a_in, b_in        signed samples
//               busy              high in LOAD and CALC
//               done              high in DONE until next start
//               best_lag/best_sum peak lag and its correlation
//               lag_valid/lag_idx/lag_sum  per-lag result stream
//
// Config      : CC_LAGSTREAM_EN  when defined, lag_valid pulses once per lag
//                                with lag_idx/lag_sum; otherwise these are 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module cc_param #(
    parameter  int W    = 16,
    parameter  int N    = 64,
    parameter  int LMAX = 32,
    localparam int ACCW = 2 * W + $clog2(N),
    localparam int LAGW = $clog2(LMAX + 1) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [W-1:0]    a_in,
    input  logic signed [W-1:0]    b_in,
    output logic                   busy,
    output logic                   done,
    output logic signed [LAGW-1:0] best_lag,
    output logic signed [ACCW-1:0] best_sum,
    output logic                   lag_valid,
    output logic signed [LAGW-1:0] lag_idx,
    output logic signed [ACCW-1:0] lag_sum
);

    localparam int AW = $clog2(N);
    // b index = n + lag spans -(N-1)..2N-2, so two extra bits cover it signed
    localparam int IW = AW + 2;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_CALC = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic        [AW:0]     c_N_CNT   = {1'b1, {AW{1'b0}}};
    localparam logic        [AW:0]     c_CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic        [AW-1:0]   c_ADR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic signed [LAGW-1:0] c_LAG_MAX = LAGW'(LMAX);
    localparam logic signed [LAGW-1:0] c_LAG_MIN = -c_LAG_MAX;
    localparam logic signed [LAGW-1:0] c_LAG_ONE = {{(LAGW-1){1'b0}}, 1'b1};
    localparam logic signed [ACCW-1:0] c_ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic signed [W-1:0] r_a_mem [N];
    logic signed [W-1:0] r_b_mem [N];
    logic [AW-1:0]       r_wr_addr;

    logic [AW:0]            r_n;        // 0..N-1 read cycles, N = drain/compare
    logic signed [LAGW-1:0] r_lag;
    logic signed [W-1:0]    r_a_rd;
    logic signed [W-1:0]    r_b_rd;
    logic                   r_b_ok;
    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] r_max_sum;
    logic signed [LAGW-1:0] r_max_lag;
    logic signed [LAGW-1:0] r_best_lag;
    logic signed [ACCW-1:0] r_best_sum;

    logic                   w_accept;
    logic                   w_cmp;
    logic                   w_last;
    logic                   w_take;
    logic signed [IW-1:0]   w_b_idx;
    logic                   w_b_ok;
    logic signed [2*W-1:0]  w_mul;
    logic signed [2*W-1:0]  w_prod;
    logic signed [ACCW-1:0] w_sum;

    assign in_ready = (r_state == c_ST_LOAD);
    assign busy     = (r_state == c_ST_LOAD) || (r_state == c_ST_CALC);
    assign done     = (r_state == c_ST_DONE);
    assign best_lag = r_best_lag;
    assign best_sum = r_best_sum;

    assign w_accept = in_valid && in_ready;
    assign w_cmp    = (r_state == c_ST_CALC) && (r_n == c_N_CNT);
    assign w_last   = w_cmp && (r_lag == c_LAG_MAX);

    assign w_b_idx = {2'b00, r_n[AW-1:0]} + {{(IW-LAGW){r_lag[LAGW-1]}}, r_lag};
    assign w_b_ok  = (w_b_idx[IW-1:AW] == 2'b00);

    // Multiply in its own signed context; masking with a ternary against an
    // unsigned zero would otherwise turn the product unsigned.
    assign w_mul  = r_a_rd * r_b_rd;
    assign w_prod = r_b_ok ? w_mul : '0;
    assign w_sum  = r_acc + {{(ACCW-2*W){w_prod[2*W-1]}}, w_prod};
    // Strictly greater: an equal later lag never displaces an earlier one
    assign w_take = (w_sum > r_max_sum);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: if (w_accept && (&r_wr_addr)) w_state_nxt = c_ST_CALC;
            c_ST_CALC: if (w_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (start) w_state_nxt = c_ST_LOAD;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Window capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_mem[r_wr_addr] <= a_in;
            r_b_mem[r_wr_addr] <= b_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != c_ST_LOAD)) begin
            r_wr_addr <= '0;
        end else if (w_accept) begin
            r_wr_addr <= r_wr_addr + c_ADR_ONE;
        end
    end

    // Registered array reads. The drain cycle (r_n == N) also issues a read
    // whose data lands on r_n == 0 of the next lag, where it is ignored.
    always_ff @(posedge clk) begin
        r_a_rd <= r_a_mem[r_n[AW-1:0]];
        r_b_rd <= r_b_mem[w_b_idx[AW-1:0]];
    end

    // ------------------------------------------------------------------
    // MAC, lag sequencing and peak tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n        <= '0;
            r_lag      <= '0;
            r_b_ok     <= 1'b0;
            r_acc      <= '0;
            r_max_sum  <= c_ACC_MIN;
            r_max_lag  <= '0;
            r_best_lag <= '0;
            r_best_sum <= '0;
        end else begin
            r_b_ok <= w_b_ok;

            if (r_state != c_ST_CALC) begin
                r_n       <= '0;
                r_lag     <= c_LAG_MIN;
                r_acc     <= '0;
                r_max_sum <= c_ACC_MIN;
                r_max_lag <= c_LAG_MIN;
            end else if (w_cmp) begin
                r_n   <= '0;
                r_lag <= r_lag + c_LAG_ONE;
                r_acc <= '0;
                if (w_take) begin
                    r_max_sum <= w_sum;
                    r_max_lag <= r_lag;
                end
            end else begin
                r_n <= r_n + c_CNT_ONE;
                // No product is pending on the first cycle of a lag
                r_acc <= (r_n == '0) ? '0 : w_sum;
            end

            if (w_last) begin
                r_best_sum <= w_take ? w_sum : r_max_sum;
                r_best_lag <= w_take ? r_lag : r_max_lag;
            end else if ((r_state == c_ST_DONE) && start) begin
                r_best_sum <= '0;
                r_best_lag <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional per-lag result stream
    // ------------------------------------------------------------------
`ifdef CC_LAGSTREAM_EN
    logic                   r_lag_valid;
    logic signed [LAGW-1:0] r_lag_idx;
    logic signed [ACCW-1:0] r_lag_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lag_valid <= 1'b0;
            r_lag_idx   <= '0;
            r_lag_sum   <= '0;
        end else begin
            r_lag_valid <= w_cmp;
            if (w_cmp) begin
                r_lag_idx <= r_lag;
                r_lag_sum <= w_sum;
            end
        end
    end

    assign lag_valid = r_lag_valid;
    assign lag_idx   = r_lag_idx;
    assign lag_sum   = r_lag_sum;
`else
    assign lag_valid = 1'b0;
    assign lag_idx   = '0;
    assign lag_sum   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cc_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cc_param
// Description : Directed self-checking bench for cc_param at W=8, N=16,
//               LMAX=4 (ACCW=20, LAGW=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_cc_param;

    localparam int W    = 8;
    localparam int N    = 16;
    localparam int LMAX = 4;
    localparam int ACCW = 20;
    localparam int LAGW = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [W-1:0]    a_in;
    logic signed [W-1:0]    b_in;
    logic                   busy;
    logic                   done;
    logic signed [LAGW-1:0] best_lag;
    logic signed [ACCW-1:0] best_sum;
    logic                   lag_valid;
    logic signed [LAGW-1:0] lag_idx;
    logic signed [ACCW-1:0] lag_sum;

    int checks = 0;
    int errors = 0;

    int ra [N];
    int rb [N];
    int pulse_cyc [$];
    int pulse_lag [$];
    int pulse_sum [$];

    // Test-1 window: b is a delayed by two samples
    int vec1 [N] = '{3, -5, 7, 1, -2, 4, -6, 8, 2, -3, 5, -1, 6, -4, 9, -7};

    cc_param #(.W(W), .N(N), .LMAX(LMAX)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .best_lag  (best_lag),
        .best_sum  (best_sum),
        .lag_valid (lag_valid),
        .lag_idx   (lag_idx),
        .lag_sum   (lag_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direct evaluation of the correlation definition
    task automatic ref_best(output int blag, output int bsum);
        int s;
        blag = 0;
        bsum = 0;
        for (int lag = -LMAX; lag <= LMAX; lag++) begin
            s = 0;
            for (int n = 0; n < N; n++) begin
                if ((n + lag >= 0) && (n + lag < N)) s += ra[n] * rb[n + lag];
            end
            if ((lag == -LMAX) || (s > bsum)) begin
                bsum = s;
                blag = lag;
            end
        end
    endtask

    task automatic set_vec1();
        for (int n = 0; n < N; n++) begin
            ra[n] = vec1[n];
            rb[n] = (n < 2) ? 0 : vec1[n - 2];
        end
    endtask

    task automatic set_const(input int av, input int bv);
        for (int n = 0; n < N; n++) begin
            ra[n] = av;
            rb[n] = bv;
        end
    endtask

    // Pulse start, then feed the window; returns cycles spent in LOAD
    task automatic run_load(input string tag, input bit gaps, input bit chk_clear,
                            output int load_cycles);
        int  idx;
        bit  tog;
        bit  hs;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (chk_clear) begin
            check({tag, "_clr_done"}, done, 0);
            check({tag, "_clr_lag"}, best_lag, 0);
            check({tag, "_clr_sum"}, best_sum, 0);
        end
        idx = 0;
        tog = 1'b1;
        load_cycles = 0;
        while ((idx < N) && (load_cycles < 200)) begin
            in_valid = gaps ? tog : 1'b1;
            tog      = ~tog;
            a_in     = W'(ra[idx]);
            b_in     = W'(rb[idx]);
            hs       = in_valid && in_ready;
            tick();
            load_cycles++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        check({tag, "_loaded"}, idx, N);
    endtask

    // Wait for done; optionally pulse start at a given CALC cycle
    task automatic wait_done(input int start_at, output int calc_cycles);
        pulse_cyc.delete();
        pulse_lag.delete();
        pulse_sum.delete();
        calc_cycles = 0;
        while (!done && (calc_cycles < 1000)) begin
            if (calc_cycles == start_at) start = 1'b1;
            tick();
            start = 1'b0;
            calc_cycles++;
            if (lag_valid) begin
                pulse_cyc.push_back(calc_cycles);
                pulse_lag.push_back(int'(lag_idx));
                pulse_sum.push_back(int'(lag_sum));
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_best_lag"}, best_lag, 0);
        check({tag, "_best_sum"}, best_sum, 0);
        check({tag, "_lag_valid"}, lag_valid, 0);
        check({tag, "_lag_idx"}, lag_idx, 0);
        check({tag, "_lag_sum"}, lag_sum, 0);
    endtask

    initial begin
        int lc;
        int cc;
        int rlag;
        int rsum;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset");

        // 1: delayed copy, peak at +2 with energy of a[0..13]
        set_vec1();
        run_load("t1", 1'b0, 1'b0, lc);
        check("t1_load_cycles", lc, 16);
        check("t1_calc_busy", busy, 1);
        check("t1_calc_in_ready", in_ready, 0);
        wait_done(-1, cc);
        check("t1_calc_cycles", cc, 153);
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 0);
        check("t1_best_lag", best_lag, 2);
        check("t1_best_sum", best_sum, 295);
        ref_best(rlag, rsum);
        check("t1_ref_lag", best_lag, rlag);
        check("t1_ref_sum", best_sum, rsum);

        // 2: all zero, started from DONE; every lag ties, -LMAX kept
        set_const(0, 0);
        run_load("t2", 1'b0, 1'b1, lc);
        wait_done(-1, cc);
        check("t2_calc_cycles", cc, 153);
        check("t2_best_lag", best_lag, -4);
        check("t2_best_sum", best_sum, 0);

        // 3: full-scale negative samples, (16-|lag|)*16384 peaks at lag 0
        set_const(-128, -128);
        run_load("t3", 1'b0, 1'b1, lc);
        wait_done(-1, cc);
        check("t3_best_lag", best_lag, 0);
        check("t3_best_sum", best_sum, 262144);

        // 4: gappy load and a start pulse mid-CALC that must be ignored
        set_vec1();
        run_load("t4", 1'b1, 1'b1, lc);
        check("t4_load_cycles", lc, 31);
        wait_done(20, cc);
        check("t4_calc_cycles", cc, 153);
        check("t4_best_lag", best_lag, 2);
        check("t4_best_sum", best_sum, 295);

        // 5: reset at CALC cycle 50, then a fresh run
        set_vec1();
        run_load("t5a", 1'b0, 1'b1, lc);
        repeat (50) tick();
        check("t5_mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("t5_rst");
        set_const(-128, -128);
        run_load("t5b", 1'b0, 1'b0, lc);
        wait_done(-1, cc);
        check("t5_calc_cycles", cc, 153);
        check("t5_best_lag", best_lag, 0);
        check("t5_best_sum", best_sum, 262144);

`ifdef CC_LAGSTREAM_EN
        // 6: impulse at n=8 in both streams; only lag 0 correlates
        set_const(0, 0);
        ra[8] = 1;
        rb[8] = 1;
        run_load("t6", 1'b0, 1'b1, lc);
        wait_done(-1, cc);
        check("t6_pulses", pulse_cyc.size(), 9);
        for (int i = 0; i < pulse_cyc.size(); i++) begin
            check($sformatf("t6_lag_idx%0d", i), pulse_lag[i], i - LMAX);
            check($sformatf("t6_lag_sum%0d", i), pulse_sum[i], (i == LMAX) ? 1 : 0);
            check($sformatf("t6_cycle%0d", i), pulse_cyc[i], 17 * (i + 1));
        end
        check("t6_best_lag", best_lag, 0);
        check("t6_best_sum", best_sum, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
